// File: rtl/pwm_pkg.sv
// Shared constants for the PWM/timer peripheral: register map indices and CTRL field layout.
// The optional IRQ field positions are used only when PWM_IRQ_EN is defined.
package pwm_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam logic [2:0]  PWM_PERIPH_ID = 3'b001;
  localparam int unsigned PWM_CNT_W     = 16;
  localparam int unsigned PWM_PRESC_W   = 8;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_POL_BIT      = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 2;
  localparam int unsigned CTRL_IRQ_PEND_BIT = 3;
  localparam int unsigned CTRL_PRESC_LSB    = 8;
  localparam int unsigned CTRL_PRESC_MSB    = 15;

endpackage

// File: rtl/pwm_timer_if.sv
// CPU data-bus view of the PWM/timer peripheral (address, write data, strobes, registered read data).
interface pwm_timer_if;
  import pwm_pkg::*;

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              write_enable;
  logic              read_enable;

  modport master (output addr, data_in, write_enable, read_enable, input data_out);
  modport slave  (input addr, data_in, write_enable, read_enable, output data_out);
endinterface

// File: rtl/pwm_prescaler.sv
// Prescaler for the PWM counter: counts 0..presc while enabled and flags the terminal cycle.
module pwm_prescaler #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] presc,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  // Restart on reaching presc; >= also recovers if presc is lowered below the running count.
  always_comb begin : cnt_next
    cnt_d = cnt_q + W'(1);
    if (!en || (cnt_q >= presc)) begin
      cnt_d = '0;
    end
  end

  assign tick = en && (cnt_q == presc);

  always_ff @(posedge clk or posedge reset) begin : cnt_reg
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_timer.sv
// Memory-mapped PWM/timer: bus decode, double-buffered period/duty, prescaled counter, compare, read mux.
// Define PWM_IRQ_EN to add the irq output with CTRL[2] irq_en and CTRL[3] irq_pend (write-1-to-clear).
module pwm_timer
  import pwm_pkg::*;
#(
  parameter logic [2:0]  PERIPH_ID = PWM_PERIPH_ID,
  parameter int unsigned CNT_W     = PWM_CNT_W,
  parameter int unsigned PRESC_W   = PWM_PRESC_W
) (
  input  logic       clk,
  input  logic       reset,
  pwm_timer_if.slave bus,
  output logic       pwm_out,
  output logic       wrap
`ifdef PWM_IRQ_EN
  ,
  output logic       irq
`endif
);

  logic               en_q, en_d, pol_q, pol_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   period_sh_q, period_sh_d, duty_sh_q, duty_sh_d;
  logic [CNT_W-1:0]   period_act_q, period_act_d, duty_act_q, duty_act_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d, ctrl_rd;
  logic               pwm_q, pwm_d, wrap_q, wrap_d;
  logic               sel, wr_en, rd_en, tick, wrap_evt;
  logic [1:0]         idx;
  logic               unused_bus_bits;
`ifdef PWM_IRQ_EN
  logic               irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_q;
`endif

  assign sel   = (bus.addr[31:29] == PERIPH_ID);
  assign idx   = bus.addr[3:2];
  assign wr_en = sel && bus.write_enable;
  assign rd_en = sel && bus.read_enable;
  assign unused_bus_bits = ^{bus.addr[28:4], bus.addr[1:0], bus.data_in[DATA_W-1:CNT_W]};

  pwm_prescaler #(.W(PRESC_W)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en_q),
    .presc (presc_q),
    .tick  (tick)
  );

  // Register writes: CTRL is live next cycle, PERIOD/DUTY only reach the shadow copies.
  always_comb begin : reg_next
    en_d        = en_q;
    pol_d       = pol_q;
    presc_d     = presc_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    if (wr_en) begin
      case (idx)
        REG_CTRL: begin
          en_d    = bus.data_in[CTRL_EN_BIT];
          pol_d   = bus.data_in[CTRL_POL_BIT];
          presc_d = bus.data_in[CTRL_PRESC_LSB +: PRESC_W];
        end
        REG_PERIOD: period_sh_d = bus.data_in[CNT_W-1:0];
        REG_DUTY:   duty_sh_d   = bus.data_in[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // While disabled (or just enabling) the counter sits at 0 and the active copies follow the shadows.
  always_comb begin : cnt_next
    count_d      = count_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    wrap_evt     = 1'b0;
    if (!en_d || !en_q) begin
      count_d      = '0;
      period_act_d = period_sh_d;
      duty_act_d   = duty_sh_d;
    end else if (tick) begin
      if (count_q == period_act_q) begin
        count_d      = '0;
        wrap_evt     = 1'b1;
        period_act_d = period_sh_q;
        duty_act_d   = duty_sh_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
    wrap_d = wrap_evt;
    pwm_d  = en_d ? ((count_d < duty_act_d) ^ pol_d) : pol_d;
  end

  always_comb begin : ctrl_word
    ctrl_rd                                = '0;
    ctrl_rd[CTRL_EN_BIT]                   = en_q;
    ctrl_rd[CTRL_POL_BIT]                  = pol_q;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]     = presc_q;
`ifdef PWM_IRQ_EN
    ctrl_rd[CTRL_IRQ_EN_BIT]               = irq_en_q;
    ctrl_rd[CTRL_IRQ_PEND_BIT]             = irq_pend_q;
`endif
  end

  // Reads sample pre-edge values, so a same-cycle write is not visible in the returned data.
  always_comb begin : rd_next
    data_out_d = data_out_q;
    if (rd_en) begin
      case (idx)
        REG_CTRL:   data_out_d = ctrl_rd;
        REG_PERIOD: data_out_d = DATA_W'(period_sh_q);
        REG_DUTY:   data_out_d = DATA_W'(duty_sh_q);
        REG_COUNT:  data_out_d = DATA_W'(count_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      en_q         <= 1'b0;
      pol_q        <= 1'b0;
      presc_q      <= '0;
      period_sh_q  <= '0;
      duty_sh_q    <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      pwm_q        <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      en_q         <= en_d;
      pol_q        <= pol_d;
      presc_q      <= presc_d;
      period_sh_q  <= period_sh_d;
      duty_sh_q    <= duty_sh_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      pwm_q        <= pwm_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign pwm_out      = pwm_q;
  assign wrap         = wrap_q;

`ifdef PWM_IRQ_EN
  // A wrap in the same cycle as the W1C write wins, so no pending event is lost.
  always_comb begin : irq_next
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (wr_en && (idx == REG_CTRL)) begin
      irq_en_d = bus.data_in[CTRL_IRQ_EN_BIT];
      if (bus.data_in[CTRL_IRQ_PEND_BIT]) begin
        irq_pend_d = 1'b0;
      end
    end
    if (wrap_evt && irq_en_q) begin
      irq_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : irq_regs
    if (reset) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_pend_d & irq_en_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
